// File: rtl/simple_circuit_pkg.sv
// -----------------------------------------------------------------------------
// simple_circuit_pkg
//   Shared definitions for the simple_circuit sweeper and its testbench:
//   - sweep_state_e : FSM state encoding (IDLE/SETTLE/REPORT/DONE)
//   - VEC_W         : width of the {A,B,C} stimulus vector
//   - LAST_VEC      : final vector of a sweep
//   - sc_expected() : golden {D,E} for a given {A,B,C}
// -----------------------------------------------------------------------------
package simple_circuit_pkg;

  localparam int VEC_W = 3;
  localparam logic [VEC_W-1:0] LAST_VEC = 3'd7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    REPORT = 2'd2,
    DONE   = 2'd3
  } sweep_state_e;

  // Golden model of the gate network: D = (A & B) | ~C, E = ~C.
  function automatic logic [1:0] sc_expected(input logic [VEC_W-1:0] abc);
    logic a, b, c;
    {a, b, c} = abc;
    return {(a & b) | ~c, ~c};
  endfunction

endpackage

// File: rtl/settle_timer.sv
// -----------------------------------------------------------------------------
// settle_timer
//   8-bit loadable down-counter that stops at zero.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset (count -> 0)
//   load     : load load_val this cycle (has priority over counting)
//   load_val : value to load
//   zero     : count is zero
// -----------------------------------------------------------------------------
module settle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       zero
);

  logic [7:0] count_q, count_d;

  always_comb begin
    // NOTE: default assigned first so every path drives count_d; no latch.
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != 8'd0) begin
      count_d = count_q - 8'd1;
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update
  // together on the edge regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (rst) count_q <= 8'd0;
    else     count_q <= count_d;
  end

  assign zero = (count_q == 8'd0);

endmodule

// File: rtl/simple_circuit_sweeper.sv
// -----------------------------------------------------------------------------
// simple_circuit_sweeper
//   Drives all eight {A,B,C} vectors into simple_circuit, waits SETTLE_CYCLES
//   after each, samples {D,E}, compares against the golden equations and
//   reports each vector over a valid/ready port. Counts mismatches with a
//   saturating counter.
//   Parameters: SETTLE_CYCLES (1..255), ERR_W (mismatch counter width)
//   clk, rst           : clock, synchronous active-high reset
//   start              : begin a sweep (accepted only in IDLE)
//   busy               : sweep in progress, through the done cycle
//   abc                : {A,B,C} to the circuit, A is MSB
//   d_in, e_in         : circuit outputs
//   res_valid/ready    : result handshake
//   res_vec/de/ok      : vector, sampled {D,E}, match flag
//   done               : one-cycle pulse after the last result is accepted
//   err_count          : mismatches in the current/last sweep
// -----------------------------------------------------------------------------
module simple_circuit_sweeper
  import simple_circuit_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic [VEC_W-1:0] abc,
  input  logic             d_in,
  input  logic             e_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [VEC_W-1:0] res_vec,
  output logic [1:0]       res_de,
  output logic             res_ok,
  output logic             done,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [7:0]       LOAD_VAL = 8'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  sweep_state_e     state_q, state_d;
  logic [VEC_W-1:0] abc_q, abc_d;
  logic             res_valid_q, res_valid_d;
  logic [VEC_W-1:0] res_vec_q, res_vec_d;
  logic [1:0]       res_de_q, res_de_d;
  logic             res_ok_q, res_ok_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic timer_load;
  logic timer_zero;
  logic match;

  settle_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (LOAD_VAL),
    .zero     (timer_zero)
  );

  assign match = ({d_in, e_in} == sc_expected(abc_q));

  always_comb begin
    state_d     = state_q;
    abc_d       = abc_q;
    res_valid_d = res_valid_q;
    res_vec_d   = res_vec_q;
    res_de_d    = res_de_q;
    res_ok_d    = res_ok_q;
    err_d       = err_q;
    timer_load  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SETTLE;
          abc_d      = '0;
          err_d      = '0;
          timer_load = 1'b1;
        end
      end
      SETTLE: begin
        if (timer_zero) begin
          res_de_d    = {d_in, e_in};
          res_vec_d   = abc_q;
          res_ok_d    = match;
          res_valid_d = 1'b1;
          state_d     = REPORT;
          if (!match && err_q != ERR_MAX) err_d = err_q + 1'b1;
        end
      end
      REPORT: begin
        // abc holds here, so a stalled consumer never sees the vector advance.
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          if (abc_q == LAST_VEC) begin
            state_d = DONE;
          end else begin
            abc_d      = abc_q + 1'b1;
            timer_load = 1'b1;
            state_d    = SETTLE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      abc_q       <= '0;
      res_valid_q <= 1'b0;
      res_vec_q   <= '0;
      res_de_q    <= '0;
      res_ok_q    <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      abc_q       <= abc_d;
      res_valid_q <= res_valid_d;
      res_vec_q   <= res_vec_d;
      res_de_q    <= res_de_d;
      res_ok_q    <= res_ok_d;
      err_q       <= err_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign abc       = abc_q;
  assign res_valid = res_valid_q;
  assign res_vec   = res_vec_q;
  assign res_de    = res_de_q;
  assign res_ok    = res_ok_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_simple_circuit_sweeper.sv
// -----------------------------------------------------------------------------
// tb_simple_circuit_sweeper
//   Directed bench for simple_circuit_sweeper. A behavioural simple_circuit
//   model (with selectable faults) closes the loop; a scoreboard queue holds
//   the expected result for each vector and is drained on every handshake.
//   A second instance with ERR_W=2 exercises counter saturation.
// -----------------------------------------------------------------------------
module tb_simple_circuit_sweeper;
  import simple_circuit_pkg::*;

  localparam int S = 4;

  typedef struct packed {
    logic [2:0] vec;
    logic [1:0] de;
    logic       ok;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT signals
  logic       rst, start, res_ready;
  logic       busy, res_valid, res_ok, done;
  logic [2:0] abc, res_vec;
  logic [1:0] res_de;
  logic       d_in, e_in;
  logic [3:0] err_count;
  int         fault_mode;  // 0 good, 1 D stuck-at-0, 2 D and E inverted

  // Saturation DUT signals
  logic       start_b, busy_b, res_valid_b, res_ok_b, done_b;
  logic [2:0] abc_b, res_vec_b;
  logic [1:0] res_de_b;
  logic       d_b, e_b;
  logic [1:0] err_count_b;

  // Behavioural simple_circuit with fault injection.
  function automatic logic [1:0] circuit_de(input logic [2:0] v, input int mode);
    logic d, e;
    d = (v[2] & v[1]) | ~v[0];
    e = ~v[0];
    case (mode)
      1:       d = 1'b0;
      2:       begin d = ~d; e = ~e; end
      default: ;
    endcase
    return {d, e};
  endfunction

  always_comb {d_in, e_in} = circuit_de(abc, fault_mode);
  always_comb {d_b, e_b}   = circuit_de(abc_b, 2);

  simple_circuit_sweeper #(.SETTLE_CYCLES(S), .ERR_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .abc(abc),
    .d_in(d_in), .e_in(e_in), .res_valid(res_valid), .res_ready(res_ready),
    .res_vec(res_vec), .res_de(res_de), .res_ok(res_ok), .done(done),
    .err_count(err_count)
  );

  simple_circuit_sweeper #(.SETTLE_CYCLES(2), .ERR_W(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .abc(abc_b),
    .d_in(d_b), .e_in(e_b), .res_valid(res_valid_b), .res_ready(1'b1),
    .res_vec(res_vec_b), .res_de(res_de_b), .res_ok(res_ok_b), .done(done_b),
    .err_count(err_count_b)
  );

  int   checks = 0;
  int   errors = 0;
  res_t sb_q[$];
  int   pops = 0;
  int   done_pulses = 0;
  int   bad_ok_b = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare every visible result against the queue head; pop on handshake.
  res_t head;
  always @(negedge clk) begin
    if (!rst && res_valid) begin
      check("abc_holds_in_report", abc, res_vec);
      if (sb_q.size() == 0) begin
        check("sb_unexpected_result", 32'd1, 32'd0);
      end else begin
        head = sb_q[0];
        check("res_vec", res_vec, head.vec);
        check("res_de",  res_de,  head.de);
        check("res_ok",  res_ok,  head.ok);
        if (res_ready) begin
          void'(sb_q.pop_front());
          pops++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done) done_pulses++;
    if (!rst && res_valid_b && !res_ok_b) bad_ok_b++;
  end

  task automatic push_sweep();
    logic [1:0] de;
    for (int v = 0; v < 8; v++) begin
      de = circuit_de(3'(v), fault_mode);
      sb_q.push_back('{vec: 3'(v), de: de, ok: (de == sc_expected(3'(v)))});
    end
  endtask

  task automatic check_reset_values();
    check("rst_abc",       abc,       0);
    check("rst_busy",      busy,      0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_vec",   res_vec,   0);
    check("rst_res_de",    res_de,    0);
    check("rst_res_ok",    res_ok,    0);
    check("rst_done",      done,      0);
    check("rst_err_count", err_count, 0);
  endtask

  // One sweep. lat = edges from the start edge up to the edge that samples
  // done high (done rises after edge 8*(S+1), so that is 8*(S+1)+1).
  task automatic run_sweep(input int stall_vec, input int stall_len,
                           input bit poke_start, output int lat);
    int n, stalled;
    bit poked;
    push_sweep();
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    n = 0; stalled = 0; poked = 0; lat = -1;
    while (n < 2000) begin
      @(posedge clk); #1; n++;
      if (done) begin
        lat = n + 1;
        if (poke_start) start = 1'b1;  // sampled while in DONE
        break;
      end
      if (poke_start && !poked && busy && !res_valid && abc == 3'd2) begin
        start = 1'b1;
        poked = 1;
      end else begin
        start = 1'b0;
      end
      if (res_valid && res_vec == 3'(stall_vec) && stalled < stall_len) begin
        res_ready = 1'b0;
        stalled++;
      end else begin
        res_ready = 1'b1;
      end
    end
    check("done_seen", (lat > 0), 1);
    @(posedge clk); #1; start = 1'b0; res_ready = 1'b1;
    check("busy_low_after_done", busy, 0);
    check("sb_drained", sb_q.size(), 0);
  endtask

  initial begin
    int lat, p0, d0, n;
    rst = 1'b1; start = 1'b0; start_b = 1'b0; res_ready = 1'b1; fault_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    rst = 1'b0;

    // Good circuit, no backpressure.
    p0 = pops; d0 = done_pulses;
    run_sweep(-1, 0, 0, lat);
    check("good_latency", lat, 8 * (S + 1) + 1);
    check("good_err", err_count, 0);
    check("good_abc_holds_7", abc, 7);
    check("good_results", pops - p0, 8);
    check("good_done_pulses", done_pulses - d0, 1);

    // D stuck-at-0: mismatches on 0,2,4,6,7.
    fault_mode = 1;
    run_sweep(-1, 0, 0, lat);
    check("stuck_latency", lat, 8 * (S + 1) + 1);
    check("stuck_err", err_count, 5);
    repeat (4) @(posedge clk);
    #1;
    check("stuck_err_held", err_count, 5);

    // Backpressure on vec 3 for 10 cycles.
    fault_mode = 0;
    p0 = pops;
    run_sweep(3, 10, 0, lat);
    check("stall_latency", lat, 8 * (S + 1) + 1 + 10);
    check("stall_results", pops - p0, 8);
    check("stall_err", err_count, 0);

    // start re-asserted during SETTLE and DONE is ignored.
    p0 = pops; d0 = done_pulses;
    run_sweep(-1, 0, 1, lat);
    check("poke_latency", lat, 8 * (S + 1) + 1);
    repeat (5) @(posedge clk);
    #1;
    check("poke_still_idle", busy, 0);
    check("poke_results", pops - p0, 8);
    check("poke_done_pulses", done_pulses - d0, 1);

    // Reset during SETTLE of vec 5 aborts the sweep.
    d0 = done_pulses;
    push_sweep();
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    n = 0;
    while (n < 500 && !(busy && !res_valid && abc == 3'd5)) begin
      @(posedge clk); #1; n++;
    end
    check("reach_vec5", (n < 500), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_values();
    rst = 1'b0;
    check("abort_pending", sb_q.size(), 3);
    sb_q.delete();
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_done", done_pulses - d0, 0);
    check("abort_idle", busy, 0);
    run_sweep(-1, 0, 0, lat);
    check("after_abort_latency", lat, 8 * (S + 1) + 1);
    check("after_abort_err", err_count, 0);

    // ERR_W=2, D and E inverted: every vector fails, counter saturates at 3.
    @(posedge clk); #1; start_b = 1'b1;
    @(posedge clk); #1; start_b = 1'b0;
    n = 0;
    while (n < 500 && !done_b) begin
      @(posedge clk); #1; n++;
    end
    check("sat_done_seen", (n < 500), 1);
    check("sat_err", err_count_b, 3);
    check("sat_bad_results", bad_ok_b, 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/simple_circuit_sweeper.md
# simple_circuit_sweeper

Self-checking sequencer for the `simple_circuit` gate network: on `start` it drives all 8 combinations of A/B/C in ascending order. For each vector it waits a programmable settle window covering the gate propagation delays, then samples D/E and compares them with the golden equations (D = (A&B)|~C, E = ~C). It reports each vector over a valid/ready result port and keeps a saturating mismatch count. It sits between a test/bring-up controller and the `simple_circuit` instance; `abc` drives A,B,C and D,E return on `d_in`/`e_in`.

## Interface
- `SETTLE_CYCLES`, default 4: cycles between applying a vector and sampling D/E; legal range 1..255.
- `ERR_W`, default 4: width of the mismatch counter.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a sweep; accepted only in IDLE.
- `busy` out 1: high from the cycle after start is accepted until the `done` cycle, inclusive.
- `abc` out 3: {A,B,C} driven to the circuit, with A as the MSB.
- `d_in` in 1: D from the circuit.
- `e_in` in 1: E from the circuit.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts the result.
- `res_vec` out 3: vector the result belongs to.
- `res_de` out 2: sampled {D,E}.
- `res_ok` out 1: 1 when `res_de` matches the expected value.
- `done` out 1: one-cycle pulse after the last result is accepted.
- `err_count` out ERR_W: number of mismatches in the current or last sweep.

## Operation
- States:
  - IDLE: waits for `start`.
  - SETTLE: `abc` is stable and `cnt` counts down.
  - REPORT: `res_valid` is held.
  - DONE: one cycle, `done`=1.
- IDLE to SETTLE happens on `start`=1. That edge sets `abc`<=0, `cnt`<=SETTLE_CYCLES-1, `err_count`<=0 and `busy`<=1.
- SETTLE:
  - If `cnt`!=0, decrement `cnt`.
  - If `cnt`==0, capture `res_de`<={d_in,e_in}, `res_vec`<=`abc` and `res_ok`<=match. Set `res_valid`<=1, go to REPORT, and increment `err_count` if there is a mismatch.
- REPORT, when `res_valid`&&`res_ready`, clears `res_valid` and then:
  - If `abc`==7, go to DONE.
  - Otherwise `abc`<=`abc`+1, `cnt`<=SETTLE_CYCLES-1, go to SETTLE.
- DONE: `done`=1 and `busy`=1 for one cycle, then IDLE with `busy`=0.
- Expected value, combinational from `abc`: D=(A&B)|~C, E=~C. Expected {D,E} for vec 0..7: 11,00,11,00,11,00,11,10.
- `err_count` saturates at 2^ERR_W-1 and never wraps. It is held after `done` until the next accepted `start`.
- `start` while not in IDLE is ignored, including during DONE.
- `abc` holds its last value (7) in IDLE after a sweep.
- `res_vec`, `res_de` and `res_ok` are stable whenever `res_valid`=1.

## Timing
- Reset values: `abc`=0, `busy`=0, `res_valid`=0, `res_vec`=0, `res_de`=0, `res_ok`=0, `done`=0, `err_count`=0, state=IDLE.
- Reset asserted mid-sweep aborts on the next edge. No `done` pulse is produced and the reset values apply.
- `start` high at edge t puts `abc`=0 after edge t. D/E are sampled at edge t+SETTLE_CYCLES, and `res_valid`=1 in that following cycle.
- With `res_ready` tied high, each vector takes SETTLE_CYCLES+1 cycles. `done` is high 8*(SETTLE_CYCLES+1)+1 cycles after the start edge.
- Backpressure: the FSM stalls in REPORT indefinitely while `res_ready`=0, and `abc` does not advance.
- A result is transferred on any edge with `res_valid`&&`res_ready`. It is never dropped or duplicated.

## Structure
- Shared package `simple_circuit_pkg`:
  - state encoding constants IDLE/SETTLE/REPORT/DONE;
  - vector width constant 3;
  - function `sc_expected(abc)` returning the 2-bit {D,E}, reused by the bench scoreboard.
- One sub-module, `settle_timer`: loadable down-counter with a `zero` flag, 8-bit, loaded with SETTLE_CYCLES-1.
- The sweeper itself holds the FSM, vector register, result registers and saturating counter.

## Test plan
- Good circuit, SETTLE_CYCLES=4, `res_ready`=1, pulse `start` → 8 results, vec 0..7, `res_de` = 11,00,11,00,11,00,11,10, all `res_ok`=1. `done` comes 41 cycles after start and `err_count`=0.
- D forced stuck-at-0 → mismatches on vec 0,2,4,6,7. `err_count`=5 and `res_ok`=0 exactly on those vectors.
- Stall: `res_ready`=0 for 10 cycles on vec 3 → `abc` stays 3, `res_*` stable, no lost or duplicate result. Total latency grows by 10.
- ERR_W=2 with D and E both inverted → all 8 vectors mismatch and `err_count` saturates at 3.
- `rst` pulsed while in SETTLE of vec 5 → next cycle all outputs are at reset values and there is no `done`. A new `start` sweeps from vec 0.
- `start` re-asserted during SETTLE and during DONE → ignored. Exactly one sweep of 8 results and one `done` pulse.
